mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one external memory bus (Wishbone-classic style, cyc/stb/ack) between the IF-stage
//  instruction port and the MEM-stage data port (the load/store/LL/SC path).
//  Sequences each access as a multi-cycle bus transaction and raises per-port stall requests
//  to the ctrl block until that port's data is ready. Sits between the pipeline and the SoC bus.
// PARAMETERS
//  TIMEOUT  255  cycles without mbus_ack_i before a transaction is aborted (8-bit counter, 1..255)
// PORTS
//  clk              in   1   single clock; all state updates on rising edge
//  rst              in   1   synchronous, active-high reset (`RstEnable)
//  flush_i          in   1   pipeline flush from ctrl (exception/eret)
//  ibus_ce_i        in   1   IF requests an instruction read
//  ibus_addr_i      in   32  instruction address (word aligned)
//  ibus_data_o      out  32  fetched instruction
//  ibus_stallreq_o  out  1   stall request for IF
//  dbus_ce_i        in   1   MEM stage requests an access (mem_ce)
//  dbus_we_i        in   1   1 = store
//  dbus_sel_i       in   4   byte lanes, bit3 = bits[31:24] (big-endian lane order)
//  dbus_addr_i      in   32  data address
//  dbus_data_i      in   32  store data
//  dbus_data_o      out  32  load data returned to MEM stage
//  dbus_stallreq_o  out  1   stall request for MEM
//  bus_err_o        out  1   one-cycle pulse: transaction timed out
//  mbus_cyc_o/mbus_stb_o  out 1  bus cycle/strobe (always driven equal)
//  mbus_we_o        out  1   bus write enable
//  mbus_sel_o       out  4   bus byte lanes
//  mbus_addr_o      out  32  bus address
//  mbus_data_o      out  32  bus write data
//  mbus_data_i      in   32  bus read data
//  mbus_ack_i       in   1   bus acknowledge, single-cycle
// BEHAVIOUR
//  - Reset: all outputs 0 (mbus_* 0, stallreq 0, data_o `ZeroWord, bus_err_o 0); FSM=IDLE; last_d=0; counter=0.
//  - FSM states: IDLE, D_BUSY, I_BUSY, D_DONE, I_DONE.
//  - IDLE: dbus_ce_i & (!ibus_ce_i | !last_d) -> D_BUSY; else ibus_ce_i -> I_BUSY; else stay.
//    Both requesting: D wins unless the previous grant was D (last_d=1) -> round-robin, no starvation.
//  - Entering *_BUSY: register addr/sel/we/data from the granted port; cyc=stb=1 from the next cycle;
//    I accesses use sel=4'b1111, we=0. Request inputs are ignored while BUSY (held by the stall).
//  - *_BUSY with mbus_ack_i: capture mbus_data_i into the port's data_o register, drop cyc/stb in the
//    same edge, go to *_DONE; last_d updated. Minimum latency: request -> data_o valid = 3 cycles.
//  - *_DONE (1 cycle): port's stallreq=0 so the pipeline advances with data_o; then IDLE.
//  - stallreq: port stalls when its ce is high and the FSM is not in that port's DONE state.
//    A port whose ce is low never stalls.
//  - Timeout: counter increments each BUSY cycle without ack; at TIMEOUT, drop cyc/stb, pulse bus_err_o,
//    data_o = `ZeroWord, go to DONE (pipeline released; exception handling is ctrl's job).
//  - flush_i during BUSY: the bus cycle is not aborted (the slave may already be writing); completion
//    goes to IDLE instead of DONE, data discarded, stallreq deasserted from the flush cycle on.
//    flush_i in IDLE/DONE: -> IDLE, no new grant that cycle.
//  - ack in IDLE/DONE (spurious): ignored.
//  - rst mid-transaction: cyc/stb drop at that edge; no completion is reported.
//  - Store data/sel pass through unmodified: lane replication is done upstream in MEM.
// STRUCTURE
//  - defines.v: state encodings `ArbIdle/`ArbDBusy/`ArbIBusy/`ArbDDone/`ArbIDone (3-bit);
//    reuses `RstEnable, `ChipEnable, `WriteEnable, `ZeroWord.
//  - Single module; the timeout counter stays inline (no sub-module).
// TESTING
//  - Single load: dbus_ce=1, addr=0x100, ack 2 cycles after stb, data=0xDEADBEEF ->
//    dbus_data_o=0xDEADBEEF in D_DONE, dbus_stallreq low exactly that cycle.
//  - Simultaneous I and D requests, last_d=0 -> D granted first, then I; repeated contention alternates D,I,D,I.
//  - Byte store: we=1, sel=4'b0100, data=0x5A5A5A5A -> mbus_we=1, sel=0100, data unchanged; ibus idle, ibus_stallreq=0.
//  - No ack with TIMEOUT=4 -> cyc drops after 4 BUSY cycles, bus_err_o 1-cycle pulse, data_o=0, stall released.
//  - flush_i during I_BUSY, ack 3 cycles later -> ibus_data_o unchanged, FSM to IDLE, no DONE cycle.
//  - rst asserted in D_BUSY -> next edge: cyc/stb=0, all outputs at reset values; later ack ignored.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// ============================================================================
// Module : mem_bus_arbiter_pkg
// Brief  : Shared types and constants for the instruction/data bus arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_D_BUSY = 3'd1,
        ARB_I_BUSY = 3'd2,
        ARB_D_DONE = 3'd3,
        ARB_I_DONE = 3'd4
    } arb_state_e;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [3:0]  SEL_WORD  = 4'b1111;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_req_t;

    function automatic logic is_busy(input arb_state_e s);
        return (s == ARB_D_BUSY) || (s == ARB_I_BUSY);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module : mem_bus_arbiter
// Brief  : Round-robin share of one cyc/stb/ack memory bus between the IF
//          instruction port and the MEM data port, with per-port stalls.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,

    input  logic        ibus_ce_i,
    input  logic [31:0] ibus_addr_i,
    output logic [31:0] ibus_data_o,
    output logic        ibus_stallreq_o,

    input  logic        dbus_ce_i,
    input  logic        dbus_we_i,
    input  logic [3:0]  dbus_sel_i,
    input  logic [31:0] dbus_addr_i,
    input  logic [31:0] dbus_data_i,
    output logic [31:0] dbus_data_o,
    output logic        dbus_stallreq_o,

    output logic        bus_err_o,

    output logic        mbus_cyc_o,
    output logic        mbus_stb_o,
    output logic        mbus_we_o,
    output logic [3:0]  mbus_sel_o,
    output logic [31:0] mbus_addr_o,
    output logic [31:0] mbus_data_o,
    input  logic [31:0] mbus_data_i,
    input  logic        mbus_ack_i
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    arb_state_e  state_q;
    logic        last_d_q;
    logic        flushed_q;
    logic [7:0]  tmo_cnt_q;
    logic [31:0] ibus_data_q;
    logic [31:0] dbus_data_q;
    logic        bus_err_q;
    logic        mbus_cyc_q;
    logic        mbus_we_q;
    logic [3:0]  mbus_sel_q;
    logic [31:0] mbus_addr_q;
    logic [31:0] mbus_data_q;

    logic        w_busy;
    logic        w_grant_d;
    logic        w_grant_i;
    logic        w_kill;
    logic        w_timeout;
    logic        w_finish;
    logic        w_served_d;
    bus_req_t    w_req;

    // D wins a tie unless it also won the previous grant.
    assign w_busy     = is_busy(state_q);
    assign w_grant_d  = dbus_ce_i & (~ibus_ce_i | ~last_d_q);
    assign w_grant_i  = ibus_ce_i & ~w_grant_d;
    assign w_kill     = w_busy & (flush_i | flushed_q);
    assign w_timeout  = w_busy & ~mbus_ack_i & (tmo_cnt_q == TMO_LAST);
    assign w_finish   = w_busy & (mbus_ack_i | w_timeout);
    assign w_served_d = (state_q == ARB_D_BUSY);

    always_comb begin
        w_req = '0;
        if (w_grant_d) begin
            w_req.we   = dbus_we_i;
            w_req.sel  = dbus_sel_i;
            w_req.addr = dbus_addr_i;
            w_req.data = dbus_data_i;
        end else begin
            w_req.we   = 1'b0;
            w_req.sel  = SEL_WORD;
            w_req.addr = ibus_addr_i;
            w_req.data = ZERO_WORD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            last_d_q    <= 1'b0;
            flushed_q   <= 1'b0;
            tmo_cnt_q   <= 8'd0;
            ibus_data_q <= ZERO_WORD;
            dbus_data_q <= ZERO_WORD;
            bus_err_q   <= 1'b0;
            mbus_cyc_q  <= 1'b0;
            mbus_we_q   <= 1'b0;
            mbus_sel_q  <= 4'b0000;
            mbus_addr_q <= ZERO_WORD;
            mbus_data_q <= ZERO_WORD;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (!flush_i && (w_grant_d || w_grant_i)) begin
                        state_q     <= w_grant_d ? ARB_D_BUSY : ARB_I_BUSY;
                        mbus_cyc_q  <= 1'b1;
                        mbus_we_q   <= w_req.we;
                        mbus_sel_q  <= w_req.sel;
                        mbus_addr_q <= w_req.addr;
                        mbus_data_q <= w_req.data;
                        tmo_cnt_q   <= 8'd0;
                        flushed_q   <= 1'b0;
                    end
                end
                ARB_D_BUSY, ARB_I_BUSY: begin
                    // A flushed cycle still runs to completion; only its result is dropped.
                    if (flush_i) begin
                        flushed_q <= 1'b1;
                    end
                    if (w_finish) begin
                        mbus_cyc_q <= 1'b0;
                        last_d_q   <= w_served_d;
                        tmo_cnt_q  <= 8'd0;
                        flushed_q  <= 1'b0;
                        bus_err_q  <= w_timeout;
                        if (w_kill) begin
                            state_q <= ARB_IDLE;
                        end else if (w_served_d) begin
                            state_q     <= ARB_D_DONE;
                            dbus_data_q <= mbus_ack_i ? mbus_data_i : ZERO_WORD;
                        end else begin
                            state_q     <= ARB_I_DONE;
                            ibus_data_q <= mbus_ack_i ? mbus_data_i : ZERO_WORD;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end
                ARB_D_DONE, ARB_I_DONE: begin
                    state_q <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign ibus_stallreq_o = ibus_ce_i & (state_q != ARB_I_DONE) & ~w_kill;
    assign dbus_stallreq_o = dbus_ce_i & (state_q != ARB_D_DONE) & ~w_kill;

    assign ibus_data_o = ibus_data_q;
    assign dbus_data_o = dbus_data_q;
    assign bus_err_o   = bus_err_q;
    assign mbus_cyc_o  = mbus_cyc_q;
    assign mbus_stb_o  = mbus_cyc_q;
    assign mbus_we_o   = mbus_we_q;
    assign mbus_sel_o  = mbus_sel_q;
    assign mbus_addr_o = mbus_addr_q;
    assign mbus_data_o = mbus_data_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module : tb_mem_bus_arbiter
// Brief  : Directed plus randomized self-checking bench for mem_bus_arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        ibus_ce_i;
    logic [31:0] ibus_addr_i;
    logic [31:0] ibus_data_o;
    logic        ibus_stallreq_o;
    logic        dbus_ce_i;
    logic        dbus_we_i;
    logic [3:0]  dbus_sel_i;
    logic [31:0] dbus_addr_i;
    logic [31:0] dbus_data_i;
    logic [31:0] dbus_data_o;
    logic        dbus_stallreq_o;
    logic        bus_err_o;
    logic        mbus_cyc_o;
    logic        mbus_stb_o;
    logic        mbus_we_o;
    logic [3:0]  mbus_sel_o;
    logic [31:0] mbus_addr_o;
    logic [31:0] mbus_data_o;
    logic [31:0] mbus_data_i;
    logic        mbus_ack_i;

    mem_bus_arbiter #(.TIMEOUT(TMO)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush_i),
        .ibus_ce_i       (ibus_ce_i),
        .ibus_addr_i     (ibus_addr_i),
        .ibus_data_o     (ibus_data_o),
        .ibus_stallreq_o (ibus_stallreq_o),
        .dbus_ce_i       (dbus_ce_i),
        .dbus_we_i       (dbus_we_i),
        .dbus_sel_i      (dbus_sel_i),
        .dbus_addr_i     (dbus_addr_i),
        .dbus_data_i     (dbus_data_i),
        .dbus_data_o     (dbus_data_o),
        .dbus_stallreq_o (dbus_stallreq_o),
        .bus_err_o       (bus_err_o),
        .mbus_cyc_o      (mbus_cyc_o),
        .mbus_stb_o      (mbus_stb_o),
        .mbus_we_o       (mbus_we_o),
        .mbus_sel_o      (mbus_sel_o),
        .mbus_addr_o     (mbus_addr_o),
        .mbus_data_o     (mbus_data_o),
        .mbus_data_i     (mbus_data_i),
        .mbus_ack_i      (mbus_ack_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: which port won the last grant, and the request being presented.
    bit          m_last_d;
    logic [31:0] cur_iaddr;
    logic [31:0] cur_daddr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_sel;
    logic        cur_we;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Acts as the slave for one transaction of the given port and checks its outcome.
    task automatic serve(input bit port_d, input int exp_wait, input int lat,
                         input logic [31:0] rdata, input bit do_flush);
        int          w;
        bit          tmo;
        logic [31:0] old_data;
        w        = 0;
        tmo      = (lat >= TMO);
        old_data = port_d ? dbus_data_o : ibus_data_o;
        while (!mbus_cyc_o && w < 4) begin
            @(negedge clk);
            w++;
        end
        chk("grant_latency", 32'(w), 32'(exp_wait));
        if (!mbus_cyc_o) return;
        chk("bus_stb", 32'(mbus_stb_o), 32'd1);
        chk("bus_we", 32'(mbus_we_o), 32'(port_d ? cur_we : 1'b0));
        chk("bus_sel", 32'(mbus_sel_o), 32'(port_d ? cur_sel : 4'hF));
        chk("bus_addr", mbus_addr_o, port_d ? cur_daddr : cur_iaddr);
        if (port_d) chk("bus_wdata", mbus_data_o, cur_wdata);
        for (int n = 1; n <= TMO; n++) begin
            if (n == 1 && do_flush) flush_i = 1'b1;
            #1;
            chk("stall_busy", 32'(port_d ? dbus_stallreq_o : ibus_stallreq_o),
                32'(do_flush ? 1'b0 : 1'b1));
            chk("cyc_busy", 32'(mbus_cyc_o), 32'd1);
            if (n == lat + 1) begin
                mbus_ack_i  = 1'b1;
                mbus_data_i = rdata;
            end
            @(negedge clk);
            flush_i     = 1'b0;
            mbus_ack_i  = 1'b0;
            mbus_data_i = $urandom;
            if (n == lat + 1) break;
        end
        #1;
        chk("cyc_drop", 32'(mbus_cyc_o), 32'd0);
        chk("bus_err", 32'(bus_err_o), 32'(tmo));
        if (do_flush) begin
            chk("flush_data_kept", port_d ? dbus_data_o : ibus_data_o, old_data);
            chk("flush_no_done", 32'(port_d ? dbus_stallreq_o : ibus_stallreq_o), 32'd1);
            if (port_d) dbus_ce_i = 1'b0; else ibus_ce_i = 1'b0;
        end else begin
            chk("done_stall", 32'(port_d ? dbus_stallreq_o : ibus_stallreq_o), 32'd0);
            chk("done_data", port_d ? dbus_data_o : ibus_data_o, tmo ? 32'h0 : rdata);
            chk("other_stall", 32'(port_d ? ibus_stallreq_o : dbus_stallreq_o),
                32'(port_d ? ibus_ce_i : dbus_ce_i));
        end
        m_last_d = port_d;
    endtask

    task automatic round(input bit ireq, input bit dreq, input int lat_i, input int lat_d,
                         input logic [31:0] rd_i, input logic [31:0] rd_d, input bit do_flush);
        bit first_d;
        ibus_ce_i   = ireq;
        ibus_addr_i = cur_iaddr;
        dbus_ce_i   = dreq;
        dbus_we_i   = cur_we;
        dbus_sel_i  = cur_sel;
        dbus_addr_i = cur_daddr;
        dbus_data_i = cur_wdata;
        first_d = dreq && (!ireq || !m_last_d);
        serve(first_d, 1, first_d ? lat_d : lat_i, first_d ? rd_d : rd_i, do_flush);
        if (first_d) dbus_ce_i = 1'b0; else ibus_ce_i = 1'b0;
        if (ireq && dreq && !do_flush) begin
            serve(!first_d, 2, first_d ? lat_i : lat_d, first_d ? rd_i : rd_d, 1'b0);
        end
        ibus_ce_i = 1'b0;
        dbus_ce_i = 1'b0;
        @(negedge clk);
        #1;
        chk("err_pulse_end", 32'(bus_err_o), 32'd0);
    endtask

    initial begin
        logic [31:0] keep;
        rst = 1'b1; flush_i = 1'b0; mbus_ack_i = 1'b0; mbus_data_i = '0;
        ibus_ce_i = 1'b0; ibus_addr_i = '0;
        dbus_ce_i = 1'b0; dbus_we_i = 1'b0; dbus_sel_i = '0; dbus_addr_i = '0; dbus_data_i = '0;
        m_last_d = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cyc", 32'(mbus_cyc_o), 32'd0);
        chk("rst_stb", 32'(mbus_stb_o), 32'd0);
        chk("rst_ddata", dbus_data_o, 32'h0);
        chk("rst_idata", ibus_data_o, 32'h0);
        chk("rst_err", 32'(bus_err_o), 32'd0);
        chk("rst_addr", mbus_addr_o, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Contention right after reset: D first, then I, alternating each round.
        for (int k = 0; k < 3; k++) begin
            cur_iaddr = 32'h0000_1000 + 32'(k * 4); cur_daddr = 32'h0000_2000 + 32'(k * 4);
            cur_we = 1'b0; cur_sel = 4'hF; cur_wdata = 32'h0;
            round(1'b1, 1'b1, 1, 0, 32'h1111_0000 + 32'(k), 32'h2222_0000 + 32'(k), 1'b0);
        end

        // Single load.
        cur_daddr = 32'h0000_0100; cur_we = 1'b0; cur_sel = 4'hF; cur_wdata = 32'h0;
        round(1'b0, 1'b1, 0, 2, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Byte store passes sel/data through unchanged.
        cur_daddr = 32'h0000_0204; cur_we = 1'b1; cur_sel = 4'b0100; cur_wdata = 32'h5A5A_5A5A;
        round(1'b0, 1'b1, 0, 1, 32'h0, 32'hCAFE_F00D, 1'b0);

        // No ack: timeout releases the port with zero data and an error pulse.
        cur_daddr = 32'h0000_0300; cur_we = 1'b0; cur_sel = 4'hF;
        round(1'b0, 1'b1, 0, TMO, 32'h0, 32'h1234_5678, 1'b0);

        // Flush during an instruction fetch.
        cur_iaddr = 32'h0000_0400;
        round(1'b1, 1'b0, 3, 0, 32'h9999_9999, 32'h0, 1'b1);

        // Spurious ack while idle.
        keep = dbus_data_o;
        mbus_ack_i = 1'b1; mbus_data_i = 32'hBAD0_BAD0;
        @(negedge clk);
        mbus_ack_i = 1'b0;
        #1;
        chk("spurious_cyc", 32'(mbus_cyc_o), 32'd0);
        chk("spurious_data", dbus_data_o, keep);
        chk("spurious_err", 32'(bus_err_o), 32'd0);

        // Randomized rounds.
        for (int k = 0; k < 40; k++) begin
            bit ir, dr, fl;
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            if (!ir && !dr) dr = 1'b1;
            fl = (ir != dr) && ($urandom_range(0, 7) == 0);
            cur_iaddr = $urandom & 32'hFFFF_FFFC;
            cur_daddr = $urandom;
            cur_we    = 1'($urandom_range(0, 1));
            cur_sel   = 4'($urandom_range(1, 15));
            cur_wdata = $urandom;
            round(ir, dr, $urandom_range(0, 5), $urandom_range(0, 5), $urandom, $urandom, fl);
        end

        // Reset in the middle of a data access.
        cur_daddr = 32'h0000_0500; cur_we = 1'b1; cur_sel = 4'hF; cur_wdata = 32'h7777_7777;
        dbus_ce_i = 1'b1; dbus_we_i = cur_we; dbus_sel_i = cur_sel;
        dbus_addr_i = cur_daddr; dbus_data_i = cur_wdata;
        @(negedge clk);
        #1;
        chk("pre_rst_cyc", 32'(mbus_cyc_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; dbus_ce_i = 1'b0;
        m_last_d = 1'b0;
        #1;
        chk("midrst_cyc", 32'(mbus_cyc_o), 32'd0);
        chk("midrst_stb", 32'(mbus_stb_o), 32'd0);
        chk("midrst_we", 32'(mbus_we_o), 32'd0);
        chk("midrst_ddata", dbus_data_o, 32'h0);
        chk("midrst_idata", ibus_data_o, 32'h0);
        chk("midrst_dstall", 32'(dbus_stallreq_o), 32'd0);
        mbus_ack_i = 1'b1; mbus_data_i = 32'hFEED_FACE;
        @(negedge clk);
        mbus_ack_i = 1'b0;
        #1;
        chk("late_ack_data", dbus_data_o, 32'h0);
        chk("late_ack_err", 32'(bus_err_o), 32'd0);

        // Arbitration state restarts after reset: D wins the first tie again.
        cur_iaddr = 32'h0000_0600; cur_daddr = 32'h0000_0700; cur_we = 1'b0; cur_sel = 4'hF;
        round(1'b1, 1'b1, 0, 0, 32'hAAAA_0001, 32'hBBBB_0002, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
